// File: rtl/pll_seq_pkg.sv
// Shared state encodings, default timing parameters and a small helper
// for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_GATE_ON   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } seq_state_e;

    localparam int DEF_RST_CYCLES    = 64;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_GATE_DELAY    = 8;
    localparam int DEF_MAX_RETRY     = 3;

    // The retry counter sticks at 15 rather than wrapping back to zero.
    function automatic logic [3:0] retry_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous bit into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings a PLL out of reset, waits for a stable lock, then opens the output
// clock gate and releases the downstream reset; retries on failure.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int GATE_DELAY    = DEF_GATE_DELAY,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       clkout0_gate,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int RST_W  = $clog2(RST_CYCLES) + 1;
    localparam int TO_W   = $clog2(LOCK_TIMEOUT) + 1;
    localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int GATE_W = $clog2(GATE_DELAY) + 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_DELAY - 1);

    seq_state_e        state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [3:0]        retry_cnt_q, retry_cnt_d;
    logic              pll_rst_q, pll_rst_d;
    logic              gate_q, gate_d;
    logic              sys_rst_q, sys_rst_d;
    logic              ready_q, ready_d;
    logic              fail_q, fail_d;
    logic              lock;
    logic              attempt_failed;
    logic              lock_lost;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST_PLL;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stab_cnt_q  <= '0;
            gate_cnt_q  <= '0;
            retry_cnt_q <= '0;
            pll_rst_q   <= 1'b1;
            gate_q      <= 1'b0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            gate_cnt_q  <= gate_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= pll_rst_d;
            gate_q      <= gate_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    // The lock timeout saturates so a return from STABLE after expiry fails at once.
    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = '0;
        to_cnt_d       = to_cnt_q;
        stab_cnt_d     = '0;
        gate_cnt_d     = '0;
        retry_cnt_d    = retry_cnt_q;
        attempt_failed = 1'b0;
        lock_lost      = 1'b0;

        case (state_q)
            ST_RST_PLL: begin
                to_cnt_d = '0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TO_W'(1);
                if (lock) begin
                    state_d = ST_STABLE;
                end else if (to_cnt_q == TO_LAST) begin
                    attempt_failed = 1'b1;
                end
            end
            ST_STABLE: begin
                to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TO_W'(1);
                if (!lock) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d = ST_GATE_ON;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            ST_GATE_ON: begin
                if (!lock) begin
                    lock_lost = 1'b1;
                end else if (gate_cnt_q == GATE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            ST_RUN: begin
                lock_lost = !lock;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST_PLL;
            end
        endcase

        if (attempt_failed) begin
            retry_cnt_d = retry_inc(retry_cnt_q);
            state_d     = (int'(retry_cnt_q) < MAX_RETRY) ? ST_RST_PLL : ST_FAIL;
        end
        if (lock_lost) begin
            retry_cnt_d = retry_inc(retry_cnt_q);
            state_d     = ST_RST_PLL;
        end
        if (restart_req) begin
            state_d     = ST_RST_PLL;
            retry_cnt_d = '0;
            rst_cnt_d   = '0;
            to_cnt_d    = '0;
            stab_cnt_d  = '0;
            gate_cnt_d  = '0;
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_comb begin
        pll_rst_d = (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
        gate_d    = (state_d == ST_GATE_ON) || (state_d == ST_RUN);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    assign pll_rst      = pll_rst_q;
    assign clkout0_gate = gate_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign retry_cnt    = retry_cnt_q;
    assign state        = state_q;

endmodule
